// File: rtl/systolic_ctrl.sv
// Operand sequencer for a MAX_DIM x MAX_DIM multiply-accumulate PE array.
// Latches A/B on start, streams skewed rows/columns into the array edges, then flags capture and done.
module systolic_ctrl #(
    parameter int  DATA_WIDTH = 32,
    parameter int  BUS_WIDTH  = 64,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int NW         = $clog2(MAX_DIM + 1),
    localparam int CW         = $clog2(3 * MAX_DIM - 2) + 1,
    localparam int MAT_W      = MAX_DIM * MAX_DIM * DATA_WIDTH,
    localparam int VEC_W      = MAX_DIM * DATA_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [NW-1:0]              dim_i,
    input  logic                       mode_i,
    input  logic [MAT_W-1:0]           a_mat_i,
    input  logic [MAT_W-1:0]           b_mat_i,
    input  logic [MAX_DIM*MAX_DIM-1:0] carry_i,
    output logic [VEC_W-1:0]           left_o,
    output logic [VEC_W-1:0]           up_o,
    output logic                       pe_start_o,
    output logic                       pe_mode_o,
    output logic                       busy_o,
    output logic                       res_valid_o,
    output logic                       done_o,
    output logic                       overflow_o,
    output logic                       err_o
);
    localparam logic [NW-1:0] MAX_N = NW'(MAX_DIM);

    typedef enum logic [1:0] {IDLE, FEED, CAPTURE, DONE} state_t;

    state_t           state_reg;
    logic [CW-1:0]    step_reg;
    logic [NW-1:0]    n_reg;
    logic [MAT_W-1:0] a_reg;
    logic [MAT_W-1:0] b_reg;

    logic             dim_ok;
    logic [CW-1:0]    last_step;
    logic [MAT_W-1:0] a_src;
    logic [MAT_W-1:0] b_src;
    logic [NW-1:0]    n_src;
    logic [CW-1:0]    t_src;
    logic [VEC_W-1:0] left_next;
    logic [VEC_W-1:0] up_next;

    assign dim_ok    = (dim_i != '0) && (dim_i <= MAX_N);
    assign last_step = CW'(3 * int'(n_reg) - 3);

    // Outputs are registered, so the lanes are computed for the step that becomes visible next:
    // step 0 straight from the inputs on accept, otherwise the following step from the latched operands.
    assign a_src = (state_reg == IDLE) ? a_mat_i : a_reg;
    assign b_src = (state_reg == IDLE) ? b_mat_i : b_reg;
    assign n_src = (state_reg == IDLE) ? dim_i : n_reg;
    assign t_src = (state_reg == IDLE) ? '0 : step_reg + CW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_DIM; gi++) begin : g_lane
            int   k;
            logic ok;
            assign k  = int'(t_src) - gi;
            assign ok = (gi < int'(n_src)) && (k >= 0) && (k < int'(n_src));
            assign left_next[gi*DATA_WIDTH +: DATA_WIDTH] =
                ok ? a_src[(gi*MAX_DIM + k)*DATA_WIDTH +: DATA_WIDTH] : '0;
            assign up_next[gi*DATA_WIDTH +: DATA_WIDTH] =
                ok ? b_src[(k*MAX_DIM + gi)*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            step_reg    <= '0;
            n_reg       <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            left_o      <= '0;
            up_o        <= '0;
            pe_start_o  <= 1'b0;
            pe_mode_o   <= 1'b0;
            busy_o      <= 1'b0;
            res_valid_o <= 1'b0;
            done_o      <= 1'b0;
            overflow_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            res_valid_o <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            if ((state_reg == FEED || state_reg == CAPTURE) && (|carry_i)) begin
                overflow_o <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        if (dim_ok) begin
                            a_reg      <= a_mat_i;
                            b_reg      <= b_mat_i;
                            n_reg      <= dim_i;
                            pe_mode_o  <= mode_i;
                            overflow_o <= 1'b0;
                            step_reg   <= '0;
                            left_o     <= left_next;
                            up_o       <= up_next;
                            pe_start_o <= 1'b1;
                            busy_o     <= 1'b1;
                            state_reg  <= FEED;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (step_reg == last_step) begin
                        left_o      <= '0;
                        up_o        <= '0;
                        res_valid_o <= 1'b1;
                        state_reg   <= CAPTURE;
                    end else begin
                        step_reg <= step_reg + CW'(1);
                        left_o   <= left_next;
                        up_o     <= up_next;
                    end
                end
                CAPTURE: begin
                    pe_start_o <= 1'b0;
                    pe_mode_o  <= 1'b0;
                    done_o     <= 1'b1;
                    state_reg  <= DONE;
                end
                DONE: begin
                    busy_o    <= 1'b0;
                    step_reg  <= '0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized bench for systolic_ctrl: per-cycle lane/control expectations from the skew rule,
// plus a systolic-array product rebuilt from the observed streams and compared with A*B.
module tb_systolic_ctrl;
    localparam int DW = 32;
    localparam int MD = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    dim_i = '0;
    logic          mode_i = 1'b0;
    logic [127:0]  a_mat_i = '0;
    logic [127:0]  b_mat_i = '0;
    logic [3:0]    carry_i = '0;
    logic [63:0]   left_o;
    logic [63:0]   up_o;
    logic          pe_start_o, pe_mode_o, busy_o, res_valid_o, done_o, overflow_o, err_o;
    logic [5:0]    ctrl;

    int     n_checks = 0;
    int     n_errors = 0;
    int     a_m [MD][MD];
    int     b_m [MD][MD];
    longint c0;
    longint c_obs [MD][MD];
    int     lo [MD][8];
    int     uo [MD][8];
    bit     ov_model = 1'b0;
    int     op_id = 0;

    systolic_ctrl #(.DATA_WIDTH(32), .BUS_WIDTH(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .dim_i(dim_i), .mode_i(mode_i),
        .a_mat_i(a_mat_i), .b_mat_i(b_mat_i), .carry_i(carry_i),
        .left_o(left_o), .up_o(up_o), .pe_start_o(pe_start_o), .pe_mode_o(pe_mode_o),
        .busy_o(busy_o), .res_valid_o(res_valid_o), .done_o(done_o),
        .overflow_o(overflow_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;
    assign ctrl = {pe_start_o, pe_mode_o, busy_o, res_valid_o, done_o, err_o};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        a_mat_i = {$urandom, $urandom, $urandom, $urandom};
        b_mat_i = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // carry_mode: 0 none, 1 sparse random, 2 one pulse in the second busy cycle
    task automatic run_op(input int n, input bit mode, input int carry_mode, input bit poke);
        int            t;
        logic [63:0]   el, eu;
        logic [5:0]    ec;
        longint        sum, ref_v, base;
        for (int i = 0; i < MD; i++)
            for (int k = 0; k < MD; k++) begin
                a_mat_i[(i*MD+k)*DW +: DW] = a_m[i][k];
                b_mat_i[(i*MD+k)*DW +: DW] = b_m[i][k];
            end
        start_i = 1'b1;
        dim_i   = 2'(n);
        mode_i  = mode;
        carry_i = (carry_mode == 1) ? 4'($urandom_range(0, 15)) : 4'b0;
        ov_model = 1'b0;
        for (int k = 1; k <= 3*n+1; k++) begin
            @(negedge clk_i);
            t  = k - 1;
            el = '0;
            eu = '0;
            if (k <= 3*n-2)
                for (int i = 0; i < n; i++)
                    if (t - i >= 0 && t - i < n) begin
                        el[i*DW +: DW] = a_m[i][t-i];
                        eu[i*DW +: DW] = b_m[t-i][i];
                    end
            if (k <= 3*n-2)      ec = {1'b1, mode, 4'b1000};
            else if (k == 3*n-1) ec = {1'b1, mode, 4'b1100};
            else if (k == 3*n)   ec = 6'b001010;
            else                 ec = 6'b000000;
            check_val($sformatf("left_k%0d", k), left_o, el);
            check_val($sformatf("up_k%0d", k), up_o, eu);
            check_val($sformatf("ctrl_k%0d", k), 64'(ctrl), 64'(ec));
            check_val($sformatf("ovf_k%0d", k), 64'(overflow_o), 64'(ov_model));
            if (k <= 3*n-2)
                for (int i = 0; i < MD; i++) begin
                    lo[i][t] = left_o[i*DW +: DW];
                    uo[i][t] = up_o[i*DW +: DW];
                end
            if (k <= 3*n) begin
                start_i = (k < 3*n && poke) ? 1'($urandom_range(0, 1)) : 1'b0;
                dim_i   = 2'($urandom_range(0, 3));
                mode_i  = 1'($urandom_range(0, 1));
                scramble_inputs();
                case (carry_mode)
                    1:       carry_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
                    2:       carry_i = (k == 2) ? 4'b1000 : 4'b0;
                    default: carry_i = 4'b0;
                endcase
                if (k <= 3*n-1 && carry_i != 4'b0) ov_model = 1'b1;
            end
        end
        // Rebuild what PE(i,j) accumulates: row i arrives j cycles late, column j arrives i cycles late.
        base = mode ? c0 : 64'sd0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                sum = 0;
                for (int s = 0; s <= 3*n-3; s++)
                    if (s + j - i >= 0 && s + j - i <= 3*n-3)
                        sum += longint'(lo[i][s]) * longint'(uo[j][s+j-i]);
                ref_v = 0;
                for (int k = 0; k < n; k++) ref_v += longint'(a_m[i][k]) * longint'(b_m[k][j]);
                c_obs[i][j] = base + sum;
                check_val($sformatf("pe_c%0d%0d", i, j), c_obs[i][j], base + ref_v);
            end
        $display("op %0d N=%0d mode=%0d carry_mode=%0d ovf=%0d c00=%0d", op_id, n, mode, carry_mode,
                 overflow_o, c_obs[0][0]);
        op_id++;
    endtask

    task automatic bad_start(input logic [1:0] d);
        start_i = 1'b1;
        dim_i   = d;
        carry_i = 4'($urandom_range(0, 15));
        @(negedge clk_i);
        check_val($sformatf("err_dim%0d", d), 64'(ctrl), 64'(6'b000001));
        check_val("err_ovf_hold", 64'(overflow_o), 64'(ov_model));
        start_i = 1'b0;
        @(negedge clk_i);
        check_val("err_clear", 64'(ctrl), 64'(6'b000000));
        $display("bad start dim=%0d err seen busy=%0d", d, busy_o);
    endtask

    task automatic idle_cycles(input int m);
        for (int c = 0; c < m; c++) begin
            start_i = 1'b0;
            carry_i = 4'($urandom_range(0, 15));
            @(negedge clk_i);
            check_val("idle_ctrl", 64'(ctrl), 64'(6'b000000));
            check_val("idle_ovf", 64'(overflow_o), 64'(ov_model));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        check_val("rst_lanes", {left_o ^ up_o} | left_o, 64'd0);
        check_val("rst_ctrl", 64'(ctrl), 64'(6'b000000));
        check_val("rst_ovf", 64'(overflow_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed: 2x2 product, then N=1 accumulate onto preload.
        a_m = '{'{1, 2}, '{3, 4}};
        b_m = '{'{5, 6}, '{7, 8}};
        c0 = 0;
        run_op(2, 1'b0, 0, 1'b0);
        check_val("t1_c11", c_obs[1][1], 64'd50);
        a_m = '{'{-3, 0}, '{0, 0}};
        b_m = '{'{7, 0}, '{0, 0}};
        c0 = 10;
        run_op(1, 1'b1, 0, 1'b1);
        check_val("t3_c00", c_obs[0][0], -64'sd11);

        bad_start(2'd0);
        bad_start(2'd3);

        // Saturating operands with a carry pulse; overflow must hold until the next accept.
        a_m = '{'{32'h7fffffff, 32'h7fffffff}, '{32'h7fffffff, 32'h7fffffff}};
        b_m = a_m;
        c0 = 64'h7fffffff00000000;
        run_op(2, 1'b1, 2, 1'b1);
        check_val("t5_ovf_set", 64'(ov_model), 64'd1);
        idle_cycles(3);
        bad_start(2'd3);

        // Asynchronous reset in the middle of the feed.
        for (int i = 0; i < MD; i++)
            for (int k = 0; k < MD; k++)
                a_mat_i[(i*MD+k)*DW +: DW] = $urandom;
        start_i = 1'b1;
        dim_i   = 2'd2;
        mode_i  = 1'b1;
        carry_i = 4'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check_val("midrst_lanes", left_o | up_o, 64'd0);
        check_val("midrst_ctrl", 64'(ctrl), 64'(6'b000000));
        check_val("midrst_ovf", 64'(overflow_o), 64'd0);
        $display("async reset during feed outputs=%0h", ctrl);
        @(negedge clk_i);
        rst_ni   = 1'b1;
        ov_model = 1'b0;

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < MD; i++)
                for (int k = 0; k < MD; k++) begin
                    a_m[i][k] = (r % 3 == 0) ? int'($urandom_range(0, 40)) - 20 : int'($urandom);
                    b_m[i][k] = (r % 3 == 0) ? int'($urandom_range(0, 40)) - 20 : int'($urandom);
                end
            c0 = {$urandom, $urandom};
            run_op(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 5) == 0) bad_start($urandom_range(0, 1) == 0 ? 2'd0 : 2'd3);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
